// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit subtractor: one full-subtractor cell, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             br;
  logic [CNT_W-1:0] count;

  logic             d, br_nxt, last, accept;
  logic [WIDTH-1:0] diff_nxt;

  // Full-subtractor cell on the current LSB pair
  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last   = (count == CNT_W'(WIDTH - 1));
  assign accept = (state == IDLE) && start;

  // A one-bit result has no upper slice to shift down
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_nxt = d;
    end else begin : g_wn
      assign diff_nxt = {d, diff[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      count <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      count <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      br    <= br_nxt;
      diff  <= diff_nxt;
      count <= count + 1'b1;
      if (last) bout <= br_nxt;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last shift the register LSBs hold the original operand MSBs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf <= 1'b0;
    else if (accept)                   ovf <= 1'b0;
    else if ((state == SHIFT) && last) ovf <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d);
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed, randomized and a
// 4-bit exhaustive sweep against an arithmetic reference (a - b - bin).
module tb_serial_subtractor_ctrl;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, bin, busy, done, bout;
  logic [W-1:0] a, b, diff;
  logic          start4, bin4, busy4, done4, bout4;
  logic [W4-1:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full operation on the 8-bit DUT; expectations from plain arithmetic
  task automatic run_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                        input bit hold, input bit toggle);
    logic [W-1:0] ed;
    int           eb, eo, sr, j;
    ed = ra - rb - W'(rbin);
    eb = (int'(ra) < int'(rb) + int'(rbin)) ? 1 : 0;
    sr = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    eo = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;

    @(negedge clk);
    start = 1'b1; a = ra; b = rb; bin = rbin;
    @(negedge clk);
    check("busy_after_accept", int'(busy), 1);
    check("diff_cleared", int'(diff), 0);
    check("bout_cleared", int'(bout), 0);
    if (!hold) start = 1'b0;
    j = 0;
    while (!done && j < W + 4) begin
      if (toggle) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      j++;
    end
    if (!done) check("done_timeout", 0, 1);
    // clock periods counted from the one right after the accept edge
    check("latency", j + 1, W + 1);
    check("diff", int'(diff), int'(ed));
    check("bout", int'(bout), eb);
    check("busy_in_done", int'(busy), 1);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", int'(ovf), eo);
`endif
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check("diff_held", int'(diff), int'(ed));
    check("bout_held", int'(bout), eb);
  endtask

  task automatic run4(input logic [W4-1:0] ra, input logic [W4-1:0] rb, input logic rbin);
    logic [W4-1:0] ed;
    int            eb, j;
    ed = ra - rb - W4'(rbin);
    eb = (int'(ra) < int'(rb) + int'(rbin)) ? 1 : 0;
    @(negedge clk);
    start4 = 1'b1; a4 = ra; b4 = rb; bin4 = rbin;
    @(negedge clk);
    start4 = 1'b0;
    j = 0;
    while (!done4 && j < W4 + 4) begin
      @(negedge clk);
      j++;
    end
    if (!done4) check("w4_done_timeout", 0, 1);
    check("w4_diff", int'(diff4), int'(ed));
    check("w4_bout", int'(bout4), eb);
    @(negedge clk);
  endtask

  initial begin
    int any_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", int'(ovf), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 1'b0, 1'b0);
    run_op(8'h10, 8'h10, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    // start held high and operands churned while busy
    run_op(8'hC3, 8'h4D, 1'b1, 1'b1, 1'b1);

    // Reset pulse during the 4th shift cycle aborts the operation
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) any_done = 1;
    end
    check("abort_no_done", any_done, 0);
    run_op(8'h37, 8'h9A, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run4(W4'(ia), W4'(ib), 1'(ic));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
